mac_frame_fifo_sync: RTL and testbench

//  Single-clock, store-and-forward frame FIFO between MAC byte datapath and wider host bus.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_fifo_packer.sv | 56 +++++
 rtl/mac_frame_fifo_sync.sv | 140 ++++++++++++++
 tb/tb_mac_frame_fifo_sync.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC frame FIFO: RAM entry flag layout,
// lane-count width helper and the write-side state encoding.
package mac_pkg;

   // Flag positions counted down from the entry MSB; entry = {end, start, lanes, data}.
   localparam int ENT_END_OFS   = 1;
   localparam int ENT_START_OFS = 2;

   typedef enum logic {
      W_IDLE    = 1'b0,
      W_WRITING = 1'b1
   } w_state_t;

   function automatic int lanes_w(input int ratio);
      return $clog2(ratio + 1);
   endfunction

endpackage

// File: rtl/mac_fifo_packer.sv
// Packs narrow beats into one output word, first beat in the LSB lane.
// clear restarts packing; clear together with push makes the beat lane 0.
module mac_fifo_packer
   import mac_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int OUT_W  = 32,
   localparam int RATIO = OUT_W / IN_W,
   localparam int LW    = lanes_w(RATIO)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             flush,
   input  logic             clear,
   input  logic [IN_W-1:0]  beat,
   output logic [OUT_W-1:0] word,
   output logic [LW-1:0]    lanes,
   output logic             full
);

   logic [OUT_W-1:0] acc;
   logic [LW-1:0]    cnt;
   logic [OUT_W-1:0] base;
   logic [LW-1:0]    base_cnt;

   // word/lanes describe the packer contents including this cycle's beat.
   always_comb begin
      base     = clear ? '0 : acc;
      base_cnt = clear ? '0 : cnt;
      word     = base;
      for (int l = 0; l < RATIO; l++)
         if (base_cnt == LW'(l)) word[l*IN_W +: IN_W] = beat;
      lanes = base_cnt + LW'(1);
      full  = (lanes == LW'(RATIO));
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (push) begin
         if (flush | full) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= word;
            cnt <= lanes;
         end
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end
   end

endmodule

// File: rtl/mac_frame_fifo_sync.sv
// Store-and-forward frame FIFO: packs MAC beats into host words, commits whole
// frames only, drops aborted/overflowing frames, and supports read-side retry.
module mac_frame_fifo_sync
   import mac_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int MAX_FRAMES     = 8,
   localparam int RATIO         = DATA_OUT_WIDTH / DATA_IN_WIDTH,
   localparam int LW            = lanes_w(RATIO),
   localparam int FCW           = $clog2(MAX_FRAMES + 1)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [DATA_IN_WIDTH-1:0]  data_in,
   input  logic                      data_in_enable,
   input  logic                      data_in_start,
   input  logic                      data_in_end,
   input  logic                      error,
   output logic                      data_in_full,
   output logic [DATA_OUT_WIDTH-1:0] data_out,
   output logic                      data_out_valid,
   input  logic                      data_out_enable,
   output logic                      data_out_start,
   output logic                      data_out_end,
   output logic [LW-1:0]             data_out_lanes,
   input  logic                      retry,
   output logic [FCW-1:0]            frame_count,
   output logic                      frame_dropped
);

   localparam int PW = FIFO_DEPTH + 1;
   localparam int EW = DATA_OUT_WIDTH + LW + 2;
   localparam logic [PW-1:0] WORDS = PW'(1 << FIFO_DEPTH);

   logic [EW-1:0] ram [2**FIFO_DEPTH];

   w_state_t      state;
   logic          bad, first_word, partial;
   logic [PW-1:0] wr_ptr, cmt_ptr, free_ptr, rd_ptr, head_ptr;

   logic [DATA_OUT_WIDTH-1:0] pk_word;
   logic [LW-1:0]             pk_lanes;
   logic                      pk_full;

   logic          starting, act, restart, need_word, ovf_now, bad_eff;
   logic          abort, finish, commit, wr_word, drop;
   logic [PW-1:0] wr_base;
   logic [EW-1:0] head;
   logic          head_start, pop, pop_end;

   // A start beat always opens a fresh frame at the committed pointer.
   assign starting  = data_in_enable & data_in_start;
   assign act       = data_in_enable & (data_in_start | (state == W_WRITING));
   assign restart   = starting & (state == W_WRITING);
   assign wr_base   = starting ? cmt_ptr : wr_ptr;
   assign need_word = act & (pk_full | data_in_end);
   assign ovf_now   = need_word & ((wr_base - free_ptr) == WORDS);
   assign bad_eff   = (starting ? (frame_count == FCW'(MAX_FRAMES)) : bad) | ovf_now;
   assign abort     = act & error;
   assign finish    = act & data_in_end & ~error;
   assign commit    = finish & ~bad_eff;
   assign wr_word   = need_word & ~bad_eff & ~error;
   assign drop      = abort | (finish & bad_eff) | restart;

   assign data_in_full = ((wr_ptr - free_ptr) == WORDS) | (frame_count == FCW'(MAX_FRAMES));

   mac_fifo_packer #(
      .IN_W  (DATA_IN_WIDTH),
      .OUT_W (DATA_OUT_WIDTH)
   ) u_packer (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (act & ~error),
      .flush   (data_in_end),
      .clear   (starting | abort),
      .beat    (data_in),
      .word    (pk_word),
      .lanes   (pk_lanes),
      .full    (pk_full)
   );

   assign head           = ram[rd_ptr[FIFO_DEPTH-1:0]];
   assign head_start     = head[EW-ENT_START_OFS];
   assign data_out_valid = (rd_ptr != cmt_ptr);
   assign pop            = data_out_enable & data_out_valid;
   assign pop_end        = pop & head[EW-ENT_END_OFS];
   assign data_out       = data_out_valid ? head[DATA_OUT_WIDTH-1:0] : '0;
   assign data_out_lanes = data_out_valid ? head[DATA_OUT_WIDTH +: LW] : '0;
   assign data_out_start = data_out_valid & head_start;
   assign data_out_end   = data_out_valid & head[EW-ENT_END_OFS];

   always_ff @(posedge clock) begin
      if (wr_word)
         ram[wr_base[FIFO_DEPTH-1:0]] <= {data_in_end, starting | first_word, pk_lanes, pk_word};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= W_IDLE;
         bad           <= 1'b0;
         first_word    <= 1'b0;
         partial       <= 1'b0;
         wr_ptr        <= '0;
         cmt_ptr       <= '0;
         free_ptr      <= '0;
         rd_ptr        <= '0;
         head_ptr      <= '0;
         frame_count   <= '0;
         frame_dropped <= 1'b0;
      end else begin
         frame_dropped <= drop;
         if (act) begin
            state      <= (error | data_in_end) ? W_IDLE : W_WRITING;
            bad        <= bad_eff & ~error & ~data_in_end;
            first_word <= (starting | first_word) & ~wr_word;
            wr_ptr     <= (abort | (finish & bad_eff)) ? cmt_ptr : wr_base + PW'(wr_word);
         end
         if (commit)
            cmt_ptr <= wr_base + PW'(1);

         // An end pop frees the frame, so it takes priority over a rewind.
         if (retry & partial & ~pop_end)
            rd_ptr <= head_ptr;
         else if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (pop & head_start) begin
            head_ptr <= rd_ptr;
            partial  <= ~pop_end;
         end else if (pop_end) begin
            partial  <= 1'b0;
         end
         if (pop_end)
            free_ptr <= rd_ptr + PW'(1);
         frame_count <= frame_count + FCW'(commit) - FCW'(pop_end);
      end
   end

endmodule

// File: tb/tb_mac_frame_fifo_sync.sv
// Scoreboard bench for mac_frame_fifo_sync: stimulus queues expected words,
// an independent monitor checks every popped word against the queue.
module tb_mac_frame_fifo_sync;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  data_in = '0;
   logic        data_in_enable = 1'b0, data_in_start = 1'b0, data_in_end = 1'b0, error = 1'b0;
   logic        data_in_full;
   logic [31:0] data_out;
   logic        data_out_valid, data_out_start, data_out_end;
   logic        data_out_enable = 1'b0, retry = 1'b0;
   logic [2:0]  data_out_lanes;
   logic [3:0]  frame_count;
   logic        frame_dropped;

   typedef struct packed {
      logic [31:0] d;
      logic        s;
      logic        e;
      logic [2:0]  l;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   mac_frame_fifo_sync #(
      .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(32), .FIFO_DEPTH(4), .MAX_FRAMES(8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_in_enable(data_in_enable),
      .data_in_start(data_in_start), .data_in_end(data_in_end), .error(error),
      .data_in_full(data_in_full), .data_out(data_out), .data_out_valid(data_out_valid),
      .data_out_enable(data_out_enable), .data_out_start(data_out_start),
      .data_out_end(data_out_end), .data_out_lanes(data_out_lanes), .retry(retry),
      .frame_count(frame_count), .frame_dropped(frame_dropped)
   );

   // Monitor: every word the DUT hands over must match the scoreboard head.
   always @(negedge clock) begin
      exp_t got, want;
      if (reset_n && data_out_valid && data_out_enable) begin
         got = {data_out, data_out_start, data_out_end, data_out_lanes};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got d=%h s=%b e=%b l=%0d, none expected",
                     got.d, got.s, got.e, got.l);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL pop_word: got d=%h s=%b e=%b l=%0d want d=%h s=%b e=%b l=%0d",
                        got.d, got.s, got.e, got.l, want.d, want.s, want.e, want.l);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic er);
      data_in = d; data_in_enable = 1'b1; data_in_start = s; data_in_end = e; error = er;
      @(posedge clock); #1;
      data_in_enable = 1'b0; data_in_start = 1'b0; data_in_end = 1'b0; error = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic s, input logic e, input logic [2:0] l);
      exp_q.push_back({d, s, e, l});
   endtask

   task automatic drain();
      int n = 0;
      data_out_enable = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      data_out_enable = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d words left want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      exp_t w1, w2;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid",   32'(data_out_valid), 0);
      chk("rst_full",    32'(data_in_full), 0);
      chk("rst_count",   32'(frame_count), 0);
      chk("rst_data",    data_out, 0);
      chk("rst_lanes",   32'(data_out_lanes), 0);
      chk("rst_dropped", 32'(frame_dropped), 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // 20-beat frame -> 5 full words
      for (int i = 1; i <= 20; i++) beat(8'(i), i == 1, i == 20, 1'b0);
      chk("f1_count", 32'(frame_count), 1);
      chk("f1_valid", 32'(data_out_valid), 1);
      expect_word(32'h04030201, 1, 0, 3'd4);
      expect_word(32'h08070605, 0, 0, 3'd4);
      expect_word(32'h0C0B0A09, 0, 0, 3'd4);
      expect_word(32'h100F0E0D, 0, 0, 3'd4);
      expect_word(32'h14131211, 0, 1, 3'd4);
      drain();
      chk("f1_count_after", 32'(frame_count), 0);

      // 3-beat frame -> single partial word
      beat(8'h11, 1, 0, 0); beat(8'h22, 0, 0, 0); beat(8'h33, 0, 1, 0);
      expect_word(32'h00332211, 1, 1, 3'd3);
      drain();

      // aborted frame followed by a good one
      beat(8'h11, 1, 0, 0); beat(8'h22, 0, 0, 0); beat(8'h33, 0, 0, 0); beat(8'h44, 0, 0, 1);
      chk("err_pulse", 32'(frame_dropped), 1);
      chk("err_valid", 32'(data_out_valid), 0);
      for (int k = 0; k <= 10; k++) begin
         beat(8'(8'h55 + 8'h11 * k), k == 0, k == 10, 1'b0);
         if (k == 0) chk("err_pulse_end", 32'(frame_dropped), 0);
      end
      expect_word(32'h88776655, 1, 0, 3'd4);
      expect_word(32'hCCBBAA99, 0, 0, 3'd4);
      expect_word(32'h00FFEEDD, 0, 1, 3'd3);
      drain();

      // retry after two pops replays the frame from its head
      for (int i = 0; i < 20; i++) beat(8'(8'h21 + i), i == 0, i == 19, 1'b0);
      w1 = {32'h24232221, 1'b1, 1'b0, 3'd4};
      w2 = {32'h28272625, 1'b0, 1'b0, 3'd4};
      exp_q.push_back(w1);
      exp_q.push_back(w2);
      expect_word(32'h2C2B2A29, 0, 0, 3'd4);
      expect_word(32'h302F2E2D, 0, 0, 3'd4);
      expect_word(32'h34333231, 0, 1, 3'd4);
      data_out_enable = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      data_out_enable = 1'b0;
      retry = 1'b1;
      @(posedge clock); #1;
      retry = 1'b0;
      chk("retry_head_start", 32'(data_out_start), 1);
      chk("retry_head_data", data_out, 32'h24232221);
      exp_q.push_front(w2);
      exp_q.push_front(w1);
      drain();
      chk("retry_count", 32'(frame_count), 0);

      // 80-beat frame overflows 16 words and is dropped
      for (int i = 0; i < 80; i++) begin
         beat(8'(i), i == 0, i == 79, 1'b0);
         if (i == 63) chk("ovf_full", 32'(data_in_full), 1);
      end
      chk("ovf_pulse", 32'(frame_dropped), 1);
      chk("ovf_valid", 32'(data_out_valid), 0);
      chk("ovf_full_clr", 32'(data_in_full), 0);
      chk("ovf_count", 32'(frame_count), 0);

      // MAX_FRAMES committed, ninth frame dropped, then reset clears all
      for (int i = 0; i < 8; i++) beat(8'(8'hA0 + i), 1'b1, 1'b1, 1'b0);
      chk("max_count", 32'(frame_count), 8);
      chk("max_full", 32'(data_in_full), 1);
      chk("max_head", data_out, 32'h000000A0);
      beat(8'hB0, 1, 1, 0);
      chk("max_drop", 32'(frame_dropped), 1);
      chk("max_count_hold", 32'(frame_count), 8);
      reset_n = 1'b0;
      @(posedge clock); #1;
      chk("rst2_valid", 32'(data_out_valid), 0);
      chk("rst2_count", 32'(frame_count), 0);
      chk("rst2_full",  32'(data_in_full), 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
